// File: rtl/jtframe_joy_serial.sv
// Serial joystick scanner for a 74HC165-style chain: load, shift, deserialise,
// frame-level debounce and polarity correction into an active-high button vector.
//
// state  | meaning
// IDLE   | waiting for a tick with joy_en high; joy_load=1, joy_clk=0
// LOAD   | joy_load low, chain captures its parallel inputs
// SAMPLE | joy_clk low, bit k is valid on joy_data and gets captured
// CLKHI  | joy_clk high, chain shifts; last bit closes the frame
module jtframe_joy_serial #(
  parameter int JOYS     = 2,
  parameter int BITS     = 12,
  parameter int DIV      = 8,
  parameter int DEBOUNCE = 2,
  parameter int INV      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 joy_en,
  input  logic                 joy_data,
  output logic                 joy_clk,
  output logic                 joy_load,
  output logic [JOYS*BITS-1:0] joy_out,
  output logic                 frame_done,
  output logic                 changed
);

  localparam int N  = JOYS * BITS;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
  localparam logic [3:0]    DEB     = 4'(DEBOUNCE);
  localparam logic          INV_BIT = (INV != 0);

  typedef enum logic [1:0] {IDLE, LOAD, SAMPLE, CLKHI} state_t;

  state_t         state, state_d;
  logic [PW-1:0]  pcnt;
  logic           tick;
  logic [1:0]     sync;
  logic [KW-1:0]  k, k_d;
  logic [N-1:0]   sr, sr_d, prev, prev_d, out_d;
  logic [3:0]     s, s_d, s_new;
  logic           clk_d, load_d, done_d, chg_d;

  assign tick = (pcnt == P_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      sync <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      sync <= {sync[0], joy_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      sr         <= '0;
      prev       <= '0;
      s          <= '0;
      joy_out    <= '0;
      joy_clk    <= 1'b0;
      joy_load   <= 1'b1;
      frame_done <= 1'b0;
      changed    <= 1'b0;
    end else begin
      state      <= state_d;
      k          <= k_d;
      sr         <= sr_d;
      prev       <= prev_d;
      s          <= s_d;
      joy_out    <= out_d;
      joy_clk    <= clk_d;
      joy_load   <= load_d;
      frame_done <= done_d;
      changed    <= chg_d;
    end
  end

  always_comb begin
    state_d = state;
    k_d     = k;
    sr_d    = sr;
    prev_d  = prev;
    s_d     = s;
    s_new   = s;
    out_d   = joy_out;
    clk_d   = joy_clk;
    load_d  = joy_load;
    done_d  = 1'b0;
    chg_d   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          clk_d  = 1'b0;
          load_d = 1'b1;
          if (joy_en) begin
            load_d  = 1'b0;
            state_d = LOAD;
          end
        end
        LOAD: begin
          load_d  = 1'b1;
          k_d     = '0;
          state_d = SAMPLE;
        end
        SAMPLE: begin
          sr_d[k] = sync[1] ^ INV_BIT;
          clk_d   = 1'b1;
          state_d = CLKHI;
        end
        CLKHI: begin
          clk_d = 1'b0;
          if (k == K_LAST) begin
            // whole-frame debounce: any differing bit restarts the count
            s_new  = (sr == prev) ? ((s >= DEB) ? DEB : s + 4'd1) : 4'd1;
            prev_d = sr;
            s_d    = s_new;
            done_d = 1'b1;
            if (s_new >= DEB) begin
              out_d = sr;
              chg_d = (sr != joy_out);
            end
            state_d = IDLE;
          end else begin
            k_d     = k + 1'b1;
            state_d = SAMPLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_joy_serial.sv
// Bench for jtframe_joy_serial: behavioural 165 chain, frame-history debounce
// reference, directed scenarios plus randomized button patterns.
module tb_jtframe_joy_serial;
  localparam int N   = 24;
  localparam int DIV = 4;
  localparam int DEB = 2;

  logic          clk = 0, rst_n = 0, joy_en = 0;
  logic          joy_data, joy_clk, joy_load, frame_done, changed;
  logic [N-1:0]  joy_out;

  logic          force_en = 1, force_val = 0;
  logic [N-1:0]  cur_btn = '0, chain_lvl = '0;
  int            pos = 0;

  int vectors = 0, miscompares = 0;

  logic [N-1:0] hist[$];
  logic [N-1:0] m_out;

  jtframe_joy_serial #(.JOYS(2), .BITS(12), .DIV(DIV), .DEBOUNCE(DEB), .INV(1)) dut (
    .clk(clk), .rst_n(rst_n), .joy_en(joy_en), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load(joy_load), .joy_out(joy_out),
    .frame_done(frame_done), .changed(changed)
  );

  always #5 clk = ~clk;

  // 165 chain: parallel load while joy_load low, shift on each joy_clk rise;
  // pressed buttons pull the wire low.
  always @(posedge joy_clk or negedge joy_load) begin
    if (!joy_load) begin
      pos = 0;
      chain_lvl = ~cur_btn;
    end else begin
      pos = pos + 1;
    end
  end
  assign joy_data = force_en ? force_val : ((pos < N) ? chain_lvl[pos] : 1'b1);

  // Reference: joy_out takes a frame value once the last DEB frames since reset agree.
  function automatic logic model_end(input logic [N-1:0] sr);
    logic c;
    bit   same;
    c = 1'b0;
    hist.push_back(sr);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      same = 1;
      foreach (hist[i]) if (hist[i] != sr) same = 0;
      if (same) begin
        c = (sr != m_out);
        m_out = sr;
      end
    end
    return c;
  endfunction

  task automatic do_reset();
    joy_en = 0;
    rst_n  = 0;
    force_en = 0;
    repeat (3) @(negedge clk);
    hist.delete();
    m_out = '0;
    rst_n = 1;
  endtask

  task automatic scan_frame(input logic [N-1:0] btn, output bit ok,
                            output logic [N-1:0] out, output logic chg);
    cur_btn = btn;
    ok = 0; out = 'x; chg = 'x;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1; out = joy_out; chg = changed;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad_clk = 0, bad_load = 0, bad_out = 0, bad_pulse = 0;
    rst_n = 0; joy_en = 1; force_en = 1;
    for (int i = 0; i < 20; i++) begin
      force_val = ~force_val;
      @(negedge clk);
      if (joy_clk !== 1'b0) bad_clk++;
      if (joy_load !== 1'b1) bad_load++;
      if (joy_out !== '0) bad_out++;
      if (frame_done !== 1'b0 || changed !== 1'b0) bad_pulse++;
    end
    vectors++; if (bad_clk != 0)   begin miscompares++; $display("FAIL reset_joy_clk bad cycles %0d, want 0", bad_clk); end
    vectors++; if (bad_load != 0)  begin miscompares++; $display("FAIL reset_joy_load bad cycles %0d, want 0", bad_load); end
    vectors++; if (bad_out != 0)   begin miscompares++; $display("FAIL reset_joy_out bad cycles %0d, want 0", bad_out); end
    vectors++; if (bad_pulse != 0) begin miscompares++; $display("FAIL reset_pulses bad cycles %0d, want 0", bad_pulse); end
    joy_en = 0; force_en = 0;
    @(negedge clk) rst_n = 1;
    bad_clk = 0; bad_pulse = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (joy_clk !== 1'b0 || joy_load !== 1'b1) bad_clk++;
      if (frame_done !== 1'b0 || changed !== 1'b0 || joy_out !== '0) bad_pulse++;
    end
    vectors++; if (bad_clk != 0)   begin miscompares++; $display("FAIL idle_outputs bad cycles %0d, want 0", bad_clk); end
    vectors++; if (bad_pulse != 0) begin miscompares++; $display("FAIL idle_pulses bad cycles %0d, want 0", bad_pulse); end
  endtask

  task automatic test_timing();
    bit ok; logic [N-1:0] o; logic c;
    int n = 0, loads = 0, rises = 0, hl = 0, hi_bad = 0, same = 0;
    logic pclk, pload;
    do_reset();
    joy_en = 1;
    scan_frame('0, ok, o, c);
    vectors++; if (!ok) begin miscompares++; $display("FAIL timing_first_frame timeout, want frame_done"); end
    pclk = joy_clk; pload = joy_load;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n++;
      if (!joy_load) loads++;
      if (joy_clk && !pclk) rises++;
      if (joy_clk) hl++;
      else if (pclk) begin
        if (hl != DIV) hi_bad++;
        hl = 0;
      end
      if (joy_clk != pclk && joy_load != pload) same++;
      pclk = joy_clk; pload = joy_load;
      if (frame_done) break;
    end
    vectors++; if (n != 200)    begin miscompares++; $display("FAIL frame_period got %0d, want 200", n); end
    vectors++; if (loads != DIV) begin miscompares++; $display("FAIL load_low_cycles got %0d, want %0d", loads, DIV); end
    vectors++; if (rises != N)  begin miscompares++; $display("FAIL clk_rises got %0d, want %0d", rises, N); end
    vectors++; if (hi_bad != 0) begin miscompares++; $display("FAIL clk_high_len bad pulses %0d, want 0", hi_bad); end
    vectors++; if (same != 0)   begin miscompares++; $display("FAIL clk_load_same_cycle got %0d, want 0", same); end
  endtask

  task automatic test_mapping();
    bit ok; logic [N-1:0] o; logic c; int chg_cnt = 0;
    do_reset();
    joy_en = 1;
    for (int f = 0; f < 3; f++) begin
      scan_frame(24'h002001, ok, o, c);
      if (c === 1'b1) chg_cnt++;
      vectors++;
      if (!ok || o !== (f == 0 ? 24'h0 : 24'h002001)) begin
        miscompares++; $display("FAIL map_out frame %0d got %h, want %h", f, o, (f == 0 ? 24'h0 : 24'h002001));
      end
    end
    vectors++; if (chg_cnt != 1) begin miscompares++; $display("FAIL map_changed_count got %0d, want 1", chg_cnt); end
  endtask

  task automatic test_debounce();
    bit ok; logic [N-1:0] o; logic c, ec; int chg_cnt = 0;
    logic [N-1:0] seq [8] = '{24'h0, 24'h0, 24'h0, 24'h20, 24'h0, 24'h0, 24'h20, 24'h20};
    do_reset();
    joy_en = 1;
    for (int f = 0; f < 8; f++) begin
      scan_frame(seq[f], ok, o, c);
      ec = model_end(seq[f]);
      if (f < 6 && c === 1'b1) chg_cnt++;
      vectors++;
      if (!ok || o !== m_out || c !== ec) begin
        miscompares++; $display("FAIL debounce frame %0d got out=%h chg=%b, want out=%h chg=%b", f, o, c, m_out, ec);
      end
    end
    vectors++; if (chg_cnt != 0) begin miscompares++; $display("FAIL glitch_changed got %0d pulses, want 0", chg_cnt); end
    vectors++; if (o !== 24'h000020) begin miscompares++; $display("FAIL debounce_final got %h, want 000020", o); end
  endtask

  task automatic test_enable_drop();
    int rises = 0, after = 0, dones = 0, bad = 0, extra = 0;
    bit seen = 0;
    logic pclk = 0;
    do_reset();
    cur_btn = '0;
    joy_en = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (joy_clk && !pclk) begin
        rises++;
        if (rises > 10) after++;
        if (rises == 10) joy_en = 0;
      end
      pclk = joy_clk;
      if (frame_done) begin dones++; seen = 1; break; end
    end
    vectors++; if (!seen)      begin miscompares++; $display("FAIL drop_frame_done timeout, want pulse"); end
    vectors++; if (after != 14) begin miscompares++; $display("FAIL drop_remaining_clks got %0d, want 14", after); end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (joy_load !== 1'b1 || joy_clk !== 1'b0) bad++;
      if (frame_done) extra++;
    end
    vectors++; if (bad != 0 || extra != 0) begin
      miscompares++; $display("FAIL drop_idle got %0d bad cycles %0d extra frames, want 0 0", bad, extra);
    end
  endtask

  task automatic test_async_reset();
    bit ok; logic [N-1:0] o; logic c; int rises = 0, n = 0;
    logic pclk = 0;
    do_reset();
    joy_en = 1;
    scan_frame(24'h20, ok, o, c);
    scan_frame(24'h20, ok, o, c);
    vectors++; if (o !== 24'h20) begin miscompares++; $display("FAIL async_pre got %h, want 000020", o); end
    for (int i = 0; i < 1000 && rises < 7; i++) begin
      @(negedge clk);
      if (joy_clk && !pclk) rises++;
      pclk = joy_clk;
    end
    #1 rst_n = 0;
    #1;
    vectors++; if (joy_out !== '0 || joy_load !== 1'b1 || joy_clk !== 1'b0) begin
      miscompares++; $display("FAIL async_now got out=%h load=%b clk=%b, want 0 1 0", joy_out, joy_load, joy_clk);
    end
    hist.delete(); m_out = '0;
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (!joy_load) break;
    end
    vectors++; if (n != DIV) begin miscompares++; $display("FAIL first_load got %0d cycles, want %0d", n, DIV); end
    scan_frame(24'h20, ok, o, c);
    vectors++; if (!ok || o !== 24'h0 || c !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_f1 got %h chg=%b, want 000000 0", o, c);
    end
    scan_frame(24'h20, ok, o, c);
    vectors++; if (!ok || o !== 24'h20 || c !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_f2 got %h chg=%b, want 000020 1", o, c);
    end
  endtask

  task automatic test_random();
    bit ok; logic [N-1:0] o, btn; logic c, ec;
    do_reset();
    joy_en = 1;
    btn = '0;
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 2) == 0) btn = N'($urandom);
      scan_frame(btn, ok, o, c);
      ec = model_end(btn);
      vectors++;
      if (!ok || o !== m_out) begin
        miscompares++; $display("FAIL rand_out frame %0d got %h, want %h", f, o, m_out);
      end
      vectors++;
      if (c !== ec) begin
        miscompares++; $display("FAIL rand_changed frame %0d got %b, want %b", f, c, ec);
      end
    end
  endtask

  initial begin
    m_out = '0;
    test_reset();
    test_timing();
    test_mapping();
    test_debounce();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
